// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: decode/writeback <-> scoreboard bundle.
// master drives decode and writeback info; slave returns stall/pending/err.
interface reg_scoreboard_if #(
    parameter int CNT_W = 3
);
    logic [4:0]       i_id_rs1;
    logic [4:0]       i_id_rs2;
    logic             i_id_use_rs1;
    logic             i_id_use_rs2;
    logic [4:0]       i_id_rd;
    logic             i_id_reg_write;
    logic             i_issue_valid;
    logic             i_issue_long;
    logic             i_flush;
    logic             i_wb_valid;
    logic [4:0]       i_wb_rd;
    logic             o_stall;
    logic [31:0]      o_pending;
    logic [CNT_W-1:0] o_pending_count;
    logic             o_wb_err;

    modport master (
        output i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
        output i_id_rd, i_id_reg_write, i_issue_valid, i_issue_long,
        output i_flush, i_wb_valid, i_wb_rd,
        input  o_stall, o_pending, o_pending_count, o_wb_err
    );

    modport slave (
        input  i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
        input  i_id_rd, i_id_reg_write, i_issue_valid, i_issue_long,
        input  i_flush, i_wb_valid, i_wb_rd,
        output o_stall, o_pending, o_pending_count, o_wb_err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks pending long-latency destinations, stalls decode.
// Ports: i_clk, i_rst_n (async low), sb (reg_scoreboard_if.slave).
// Optional macro SCOREBOARD_BYPASS_EN: same-cycle writeback masks hazards.
module reg_scoreboard #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    reg_scoreboard_if.slave sb
);
    logic [31:0]      pend_q;
    logic [31:0]      pend_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             err_q;
    logic             err_d;

    logic [31:0] wb_oh;
    logic [31:0] rd_oh;
    logic [31:0] hz_vec;
    logic        clr;
    logic        set;
    logic        raw1;
    logic        raw2;
    logic        waw;
    logic        full;
    logic        stall;

    always_comb begin
        wb_oh = 32'd0;
        if (sb.i_wb_valid)
            wb_oh = 32'd1 << sb.i_wb_rd;
        rd_oh = 32'd1 << sb.i_id_rd;
        clr   = sb.i_wb_valid && pend_q[sb.i_wb_rd];
    end

    // Hazard view: with bypass the register being written back
    // this cycle is treated as already available.
    always_comb begin
`ifdef SCOREBOARD_BYPASS_EN
        hz_vec = pend_q & ~wb_oh;
        full   = sb.i_issue_long && !clr &&
                 (cnt_q == CNT_W'(MAX_OUTSTANDING));
`else
        hz_vec = pend_q;
        full   = sb.i_issue_long &&
                 (cnt_q == CNT_W'(MAX_OUTSTANDING));
`endif
        hz_vec[0] = 1'b0;
        raw1  = sb.i_id_use_rs1 && hz_vec[sb.i_id_rs1];
        raw2  = sb.i_id_use_rs2 && hz_vec[sb.i_id_rs2];
        waw   = sb.i_id_reg_write && hz_vec[sb.i_id_rd];
        stall = raw1 || raw2 || waw || full;
    end

    always_comb begin
        set = sb.i_issue_valid && sb.i_issue_long &&
              sb.i_id_reg_write && !stall && !sb.i_flush &&
              (sb.i_id_rd != 5'd0);
    end

    // Clear applies first, then set, so a same-register
    // set+clear leaves the bit high.
    always_comb begin
        pend_d = pend_q;
        if (clr)
            pend_d = pend_d & ~wb_oh;
        if (set)
            pend_d = pend_d | rd_oh;
        pend_d[0] = 1'b0;

        cnt_d = cnt_q;
        unique case (1'b1)
            (set && !clr): cnt_d = cnt_q + CNT_W'(1);
            (clr && !set): cnt_d = cnt_q - CNT_W'(1);
            default:       cnt_d = cnt_q;
        endcase

        err_d = sb.i_wb_valid && !pend_q[sb.i_wb_rd];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_q <= 32'd0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign sb.o_stall         = stall;
    assign sb.o_pending       = pend_q;
    assign sb.o_pending_count = cnt_q;
    assign sb.o_wb_err        = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed self-checking bench for reg_scoreboard.
// Vectors cover RAW, x0, full, WAW, wb error, set/clear, flush, reset.
module tb_reg_scoreboard;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_ok;

    reg_scoreboard_if #(.CNT_W(3)) sb_if ();

    reg_scoreboard #(
        .MAX_OUTSTANDING(4),
        .CNT_W(3)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .sb      (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_ok++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle();
        sb_if.i_id_rs1       = 5'd0;
        sb_if.i_id_rs2       = 5'd0;
        sb_if.i_id_use_rs1   = 1'b0;
        sb_if.i_id_use_rs2   = 1'b0;
        sb_if.i_id_rd        = 5'd0;
        sb_if.i_id_reg_write = 1'b0;
        sb_if.i_issue_valid  = 1'b0;
        sb_if.i_issue_long   = 1'b0;
        sb_if.i_flush        = 1'b0;
        sb_if.i_wb_valid     = 1'b0;
        sb_if.i_wb_rd        = 5'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        idle();
        sb_if.i_id_rd        = rd;
        sb_if.i_id_reg_write = 1'b1;
        sb_if.i_issue_valid  = 1'b1;
        sb_if.i_issue_long   = 1'b1;
    endtask

    task automatic wb(input logic [4:0] rd);
        sb_if.i_wb_valid = 1'b1;
        sb_if.i_wb_rd    = rd;
    endtask

    initial begin
        n_chk = 0;
        n_ok  = 0;
        idle();
        rst_n = 1'b0;
        #1;
        chk("rst_pend", sb_if.o_pending, 32'd0);
        chk("rst_cnt", 32'(sb_if.o_pending_count), 32'd0);
        chk("rst_err", 32'(sb_if.o_wb_err), 32'd0);
        chk("rst_stall", 32'(sb_if.o_stall), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // RAW on x5
        issue(5'd5);
        #1;
        chk("raw_iss_stall", 32'(sb_if.o_stall), 32'd0);
        step();
        idle();
        sb_if.i_id_rs1     = 5'd5;
        sb_if.i_id_use_rs1 = 1'b1;
        #1;
        chk("raw_pend", sb_if.o_pending, 32'h20);
        chk("raw_cnt", 32'(sb_if.o_pending_count), 32'd1);
        chk("raw_stall1", 32'(sb_if.o_stall), 32'd1);
        step();
        chk("raw_stall2", 32'(sb_if.o_stall), 32'd1);
        wb(5'd5);
        #1;
`ifdef SCOREBOARD_BYPASS_EN
        chk("raw_wb_stall", 32'(sb_if.o_stall), 32'd0);
`else
        chk("raw_wb_stall", 32'(sb_if.o_stall), 32'd1);
`endif
        step();
        sb_if.i_wb_valid = 1'b0;
        #1;
        chk("raw_clr_pend", sb_if.o_pending, 32'd0);
        chk("raw_clr_cnt", 32'(sb_if.o_pending_count), 32'd0);
        chk("raw_clr_stall", 32'(sb_if.o_stall), 32'd0);
        chk("raw_clr_err", 32'(sb_if.o_wb_err), 32'd0);

        // long op to x0
        issue(5'd0);
        step();
        idle();
        sb_if.i_id_rs1     = 5'd0;
        sb_if.i_id_use_rs1 = 1'b1;
        #1;
        chk("x0_pend", sb_if.o_pending, 32'd0);
        chk("x0_cnt", 32'(sb_if.o_pending_count), 32'd0);
        chk("x0_stall", 32'(sb_if.o_stall), 32'd0);

        // fill to MAX_OUTSTANDING
        for (int r = 1; r <= 4; r++) begin
            issue(5'(r));
            #1;
            chk("fill_stall", 32'(sb_if.o_stall), 32'd0);
            step();
        end
        issue(5'd8);
        #1;
        chk("full_cnt", 32'(sb_if.o_pending_count), 32'd4);
        chk("full_pend", sb_if.o_pending, 32'h1E);
        chk("full_stall", 32'(sb_if.o_stall), 32'd1);
        step();
        chk("full_noset", sb_if.o_pending, 32'h1E);
        wb(5'd2);
        #1;
`ifdef SCOREBOARD_BYPASS_EN
        chk("full_wb_stall", 32'(sb_if.o_stall), 32'd0);
        step();
        sb_if.i_wb_valid = 1'b0;
        #1;
`else
        chk("full_wb_stall", 32'(sb_if.o_stall), 32'd1);
        step();
        sb_if.i_wb_valid = 1'b0;
        #1;
        chk("full_rel_pend", sb_if.o_pending, 32'h1A);
        chk("full_rel_cnt", 32'(sb_if.o_pending_count), 32'd3);
        chk("full_rel_stall", 32'(sb_if.o_stall), 32'd0);
        step();
`endif
        chk("full5_pend", sb_if.o_pending, 32'h11A);
        chk("full5_cnt", 32'(sb_if.o_pending_count), 32'd4);
        idle();
        wb(5'd1);
        step();
        wb(5'd3);
        step();
        wb(5'd4);
        step();
        wb(5'd8);
        step();
        idle();
        #1;
        chk("drain_cnt", 32'(sb_if.o_pending_count), 32'd0);
        chk("drain_pend", sb_if.o_pending, 32'd0);

        // WAW on x7, then stray writeback to x9
        issue(5'd7);
        step();
        idle();
        sb_if.i_id_rd        = 5'd7;
        sb_if.i_id_reg_write = 1'b1;
        #1;
        chk("waw_stall", 32'(sb_if.o_stall), 32'd1);
        idle();
        wb(5'd9);
        step();
        idle();
        #1;
        chk("err_pulse", 32'(sb_if.o_wb_err), 32'd1);
        chk("err_cnt", 32'(sb_if.o_pending_count), 32'd1);
        chk("err_pend", sb_if.o_pending, 32'h80);
        step();
        chk("err_drop", 32'(sb_if.o_wb_err), 32'd0);

        // simultaneous clear x3 / set x6
        issue(5'd3);
        step();
        issue(5'd6);
        wb(5'd3);
        #1;
        chk("sc_stall", 32'(sb_if.o_stall), 32'd0);
        step();
        idle();
        #1;
        chk("sc_pend", sb_if.o_pending, 32'hC0);
        chk("sc_cnt", 32'(sb_if.o_pending_count), 32'd2);

        // flush suppresses set
        issue(5'd10);
        sb_if.i_flush = 1'b1;
        step();
        idle();
        #1;
        chk("flush_pend", sb_if.o_pending, 32'hC0);
        chk("flush_cnt", 32'(sb_if.o_pending_count), 32'd2);

        // async reset with 3 pending
        issue(5'd11);
        step();
        idle();
        sb_if.i_id_rs1     = 5'd6;
        sb_if.i_id_use_rs1 = 1'b1;
        #1;
        chk("pre_rst_cnt", 32'(sb_if.o_pending_count), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("arst_pend", sb_if.o_pending, 32'd0);
        chk("arst_cnt", 32'(sb_if.o_pending_count), 32'd0);
        chk("arst_stall", 32'(sb_if.o_stall), 32'd0);
        step();
        rst_n = 1'b1;
        idle();
        wb(5'd6);
        step();
        idle();
        #1;
        chk("post_rst_err", 32'(sb_if.o_wb_err), 32'd1);
        chk("post_rst_cnt", 32'(sb_if.o_pending_count), 32'd0);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
